// File: rtl/uart_pkg.sv
// Definitions shared by the axi2tx transmitter and the rx2axi receiver:
// FSM state encoding, UART line levels and a counter-width helper.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Counters that only ever hold 0 still need one bit of storage.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: pulses tick on the last clock of each bit period while
// en is high, and holds at zero while en is low.
module baud_counter
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CW   = cnt_width(CLOCKS_PER_PULSE);
    localparam logic [CW-1:0]   LAST = CW'(CLOCKS_PER_PULSE - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!en || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/axi2tx.sv
// AXI-Stream to UART transmitter: one accepted stream word is sent as
// NUM_WORDS back-to-back UART frames, lowest slice first, LSB first.
module axi2tx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int W_IN             = 16,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W_IN-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            tx
);

    localparam int            NUM_WORDS = W_IN / BITS_PER_WORD;
    localparam int            BW        = cnt_width(BITS_PER_WORD);
    localparam int            WW        = cnt_width(NUM_WORDS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_WORD - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

    generate
        if (CLOCKS_PER_PULSE < 1) begin : g_bad_cpp
            $error("axi2tx: CLOCKS_PER_PULSE must be at least 1");
        end
        if ((W_IN % BITS_PER_WORD) != 0) begin : g_bad_split
            $error("axi2tx: W_IN must be a multiple of BITS_PER_WORD");
        end
    endgenerate

    uart_state_t     r_state, w_state;
    logic [BW-1:0]   r_bit,   w_bit;
    logic [WW-1:0]   r_word,  w_word;
    logic [W_IN-1:0] r_shift, w_shift;
    logic            r_tx,    w_tx;
    logic            r_ready, w_ready;
    logic            w_tick;

    baud_counter #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .en  (r_state != IDLE),
        .tick(w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_bit   <= '0;
            r_word  <= '0;
            r_shift <= '0;
            r_tx    <= IDLE_LEVEL;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state;
            r_bit   <= w_bit;
            r_word  <= w_word;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_ready <= w_ready;
        end
    end

    // The shift register moves on every data tick, including the last bit of
    // a frame, so the next frame's LSB is already at bit 0 when DATA resumes.
    always_comb begin
        w_state = r_state;
        w_bit   = r_bit;
        w_word  = r_word;
        w_shift = r_shift;
        w_tx    = r_tx;
        w_ready = r_ready;
        case (r_state)
            IDLE: begin
                w_tx    = IDLE_LEVEL;
                w_ready = 1'b1;
                if (s_valid && r_ready) begin
                    w_shift = s_data;
                    w_word  = '0;
                    w_bit   = '0;
                    w_state = START;
                    w_ready = 1'b0;
                    w_tx    = START_BIT;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state = DATA;
                    w_bit   = '0;
                    w_tx    = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift = r_shift >> 1;
                    if (r_bit == BIT_LAST) begin
                        w_state = STOP;
                        w_tx    = STOP_BIT;
                    end else begin
                        w_bit = r_bit + 1'b1;
                        w_tx  = w_shift[0];
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_word < WORD_LAST) begin
                        w_word  = r_word + 1'b1;
                        w_state = START;
                        w_tx    = START_BIT;
                    end else begin
                        w_state = IDLE;
                        w_ready = 1'b1;
                        w_tx    = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign s_ready = r_ready;
    assign tx      = r_tx;

endmodule

// File: tb/tb_axi2tx.sv
// Self-checking bench for axi2tx: directed waveform vectors, multi-cycle
// corner sequences and a randomized loopback through a UART line decoder.
module tb_axi2tx;

    localparam int CPP = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [19:0] bits;   // line level per bit slot, first slot in bit 19
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, tx;
    logic [7:0]  s1_data = '0;
    logic        s1_valid = 1'b0;
    logic        s1_ready, tx1;

    int          n_chk = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [15:0] sent_q[$];
    int          rx_cnt = 0;
    vec_t        tbl[6];

    always #5 clk = ~clk;

    axi2tx dut (
        .clk    (clk),
        .rst    (rst),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .tx     (tx)
    );

    axi2tx #(
        .CLOCKS_PER_PULSE(1),
        .W_IN            (8),
        .BITS_PER_WORD   (8)
    ) dut1 (
        .clk    (clk),
        .rst    (rst),
        .s_data (s1_data),
        .s_valid(s1_valid),
        .s_ready(s1_ready),
        .tx     (tx1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, got, want, $time);
        end
    endtask

    // Line level of bit slot k (0..19) for a 16-bit word sent as two 8N1 frames.
    function automatic logic model_bit(input logic [15:0] d, input int k);
        int w;
        int b;
        w = k / 10;
        b = k % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[w*8 + b - 1];
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        check("ready timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [15:0] d, input logic [19:0] expb, input string name);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        s_data  = d;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 16'($urandom);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            check({name, " tx"}, 32'(tx), 32'(expb[19 - c/CPP]));
            check({name, " busy"}, 32'(s_ready), 32'd0);
            s_data = 16'($urandom);
        end
        @(negedge clk);
        check({name, " ready back"}, 32'(s_ready), 32'd1);
        check({name, " idle tx"}, 32'(tx), 32'd1);
    endtask

    // Line decoder: samples mid-bit, pairs frames into words, scoreboards.
    initial begin
        logic [7:0]  by;
        logic [7:0]  lo;
        logic [15:0] want;
        bit          have_lo;
        have_lo = 1'b0;
        by = '0;
        lo = '0;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (CPP/2) @(negedge clk);
                check("lb start", 32'(tx), 32'd0);
                for (int j = 0; j < 8; j++) begin
                    repeat (CPP) @(negedge clk);
                    by[j] = tx;
                end
                repeat (CPP) @(negedge clk);
                check("lb stop", 32'(tx), 32'd1);
                if (!have_lo) begin
                    lo      = by;
                    have_lo = 1'b1;
                end else begin
                    have_lo = 1'b0;
                    rx_cnt++;
                    if (sent_q.size() == 0) begin
                        check("lb extra word", 32'({by, lo}), 32'hFFFF_FFFF);
                    end else begin
                        want = sent_q.pop_front();
                        check("lb word", 32'({by, lo}), 32'(want));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [15:0] d;
        logic [19:0] expb;
        logic [19:0] b1;
        logic [19:0] b2;
        logic [9:0]  e10;
        logic        want_tx;
        int          gap;

        tbl[0] = '{16'hA53C, 20'b0001111001_0101001011};
        tbl[1] = '{16'h00FF, 20'b0111111111_0000000001};
        tbl[2] = '{16'h0001, 20'b0100000001_0000000001};
        tbl[3] = '{16'h8000, 20'b0000000001_0000000011};
        tbl[4] = '{16'h1234, 20'b0001011001_0010010001};
        tbl[5] = '{16'h5678, 20'b0000111101_0011010101};

        // Reset held with s_valid high
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'hA53C;
        repeat (3) begin
            @(negedge clk);
            check("reset tx", 32'(tx), 32'd1);
            check("reset ready", 32'(s_ready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready after release", 32'(s_ready), 32'd1);
        check("no accept on release edge", 32'(tx), 32'd1);
        s_valid = 1'b0;

        // Directed waveform vectors
        for (int i = 0; i < 6; i++) begin
            send_word(tbl[i].data, tbl[i].bits, $sformatf("vec%0d", i));
        end

        // Random words against the slot model
        repeat (3) begin
            d = 16'($urandom);
            for (int k = 0; k < 20; k++) expb[19-k] = model_bit(d, k);
            send_word(d, expb, "rand wave");
        end

        // Back-to-back with s_valid held and s_data scrambled mid-frame
        b1 = tbl[4].bits;
        b2 = tbl[5].bits;
        wait_ready(ok);
        if (ok) begin
            s_data  = 16'h1234;
            s_valid = 1'b1;
            @(posedge clk);
            #1;
            s_data = 16'($urandom);
            for (int c = 0; c <= 161; c++) begin
                @(negedge clk);
                if (c < 80)       want_tx = b1[19 - c/CPP];
                else if (c <= 80) want_tx = 1'b1;
                else if (c < 161) want_tx = b2[19 - (c-81)/CPP];
                else              want_tx = 1'b1;
                check("b2b tx", 32'(tx), 32'(want_tx));
                check("b2b ready", 32'(s_ready), (c == 80 || c == 161) ? 32'd1 : 32'd0);
                s_data  = (c == 80) ? 16'h5678 : 16'($urandom);
                s_valid = (c <= 80);
            end
        end
        s_valid = 1'b0;

        // Reset while a zero data bit is on the line
        wait_ready(ok);
        if (ok) begin
            s_data  = 16'h0000;
            s_valid = 1'b1;
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            check("pre-reset tx", 32'(tx), 32'd0);
            #1;
            rst = 1'b1;
            #1;
            check("async reset tx", 32'(tx), 32'd1);
            check("async reset ready", 32'(s_ready), 32'd0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (5) begin
                @(negedge clk);
                check("no resume tx", 32'(tx), 32'd1);
            end
            send_word(16'h00FF, tbl[1].bits, "post-reset");
        end

        // CLOCKS_PER_PULSE=1, W_IN=8 instance
        @(negedge clk);
        check("corner ready", 32'(s1_ready), 32'd1);
        s1_data  = 8'h81;
        s1_valid = 1'b1;
        @(posedge clk);
        #1;
        s1_valid = 1'b0;
        s1_data  = 8'($urandom);
        e10 = 10'b0100000011;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("corner tx", 32'(tx1), 32'(e10[9-c]));
            check("corner busy", 32'(s1_ready), 32'd0);
        end
        @(negedge clk);
        check("corner ready back", 32'(s1_ready), 32'd1);
        check("corner idle tx", 32'(tx1), 32'd1);

        // Randomized loopback through the line decoder
        wait_ready(ok);
        mon_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (n > 0) wait_ready(ok);
            if (!ok) break;
            gap = $urandom_range(0, 20);
            repeat (gap) begin
                s_data = 16'($urandom);
                @(negedge clk);
            end
            d       = 16'($urandom);
            s_data  = d;
            s_valid = 1'b1;
            sent_q.push_back(d);
            @(posedge clk);
            #1;
            for (int c = 0; c < 70; c++) begin
                s_data  = 16'($urandom);
                s_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            s_valid = 1'b0;
        end
        wait_ready(ok);
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        check("lb word count", 32'(rx_cnt), 32'd100);
        check("lb leftover", 32'(sent_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axi2tx.md
# axi2tx

AXI-Stream-to-UART transmitter. It accepts one W_IN-bit word on an AXI-Stream slave handshake and splits it into NUM_WORDS UART frames of BITS_PER_WORD data bits each. It then serializes the frames on `tx` at CLOCKS_PER_PULSE clocks per bit. It is the transmit-side counterpart of the rx2axi receiver: with matching parameters, its output on `tx` is decoded by rx2axi back to the same W_IN-bit word.

## Interface
- CLOCKS_PER_PULSE, 4, clock cycles per UART bit; must be ≥1.
- W_IN, 16, width of the stream word.
- BITS_PER_WORD, 8, data bits per UART frame; W_IN % BITS_PER_WORD must be 0, checked at elaboration.
- NUM_WORDS, W_IN/BITS_PER_WORD, frames per stream word; derived, not overridable.

- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  W_IN  stream payload; word i is s_data[i*BITS_PER_WORD +: BITS_PER_WORD].
- s_valid  in  1  payload valid.
- s_ready  out  1  registered; high only when IDLE and able to accept.
- tx  out  1  registered UART line; idles at 1.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- Counters:
  - pulse counter: 0..CLOCKS_PER_PULSE-1.
  - bit counter: 0..BITS_PER_WORD-1.
  - word counter: 0..NUM_WORDS-1. Each counter is at least 1 bit wide, so NUM_WORDS=1 and CLOCKS_PER_PULSE=1 are legal.
- IDLE:
  - tx=1, s_ready=1.
  - On an edge with s_valid && s_ready: latch s_data into the shift register, clear the word counter, go to START, drive s_ready←0 and tx←0.
- START: tx=0 for CLOCKS_PER_PULSE cycles, then go to DATA.
- DATA: tx = current word bit, LSB first; each bit is held CLOCKS_PER_PULSE cycles. After BITS_PER_WORD bits, go to STOP.
- STOP:
  - tx=1 for CLOCKS_PER_PULSE cycles.
  - If the word counter is below NUM_WORDS-1: increment it and go straight to START (no extra idle between frames of one transfer).
  - Otherwise go to IDLE and set s_ready←1.
- Word order: word 0 (s_data LSBs) is sent first.
- s_data and s_valid are ignored outside IDLE. The latched copy is immune to input changes.
- s_valid may drop before acceptance without effect; nothing is sent.

## Timing
- Reset values: tx=1, s_ready=0, state=IDLE, all counters 0, shift register 0.
- First rising edge after rst deasserts: s_ready←1. No transfer can be accepted on that edge.
- Acceptance edge A: tx is 0 from A onward, and the start bit is exactly CLOCKS_PER_PULSE cycles.
- Frame length: (BITS_PER_WORD+2)·CLOCKS_PER_PULSE cycles. With defaults this is 40 cycles per frame and 80 per transfer.
- At edge A + NUM_WORDS·(BITS_PER_WORD+2)·CLOCKS_PER_PULSE: s_ready←1 and tx stays 1.
- Back-to-back with s_valid held high: the next acceptance falls one cycle later, so start bits are 81 cycles apart with defaults. The line is high for at least CLOCKS_PER_PULSE+1 cycles between transfers.
- rst asserted mid-frame:
  - tx→1 and s_ready→0 immediately (asynchronous).
  - The in-flight word is discarded and never resumed.
  - The receiver sees a truncated frame; recovery is the receiver's responsibility.
- s_valid and s_ready carry no combinational path; the slave handshake is fully registered.

## Structure
- Shared package `uart_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t`.
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
  - The receiver and transmitter both import it.
- Sub-module `baud_counter` (parameter CLOCKS_PER_PULSE; ports clk, rst, en, tick):
  - Pulses `tick` on the last cycle of each bit period while `en` is high.
  - Clears to 0 when `en` is low.
- Everything else stays in `axi2tx`: FSM, bit/word counters, and the right-shift register emitting bit 0.

## Test plan
- Reset: hold rst 3 cycles with s_valid=1 → tx=1 and s_ready=0 throughout; s_ready=1 on the first edge after release; no acceptance on that edge.
- Single transfer, defaults, s_data=16'hA53C:
  - tx per 4-cycle bit = 0,0,0,1,1,1,1,0,0,1 then 0,1,0,1,0,0,1,0,1,1.
  - s_ready low for exactly 80 cycles.
- Back-to-back: s_valid held with 16'h1234 then 16'h5678, and s_data toggled randomly mid-frame → both words are sent intact, with start-bit falling edges exactly 81 cycles apart.
- Reset mid-operation: assert rst 20 cycles after acceptance → tx=1 in the same cycle and s_ready=0. After release, 16'h00FF transmits cleanly and the line decodes to 0xFF then 0x00.
- Parameter corner: CLOCKS_PER_PULSE=1, W_IN=8, s_data=8'h81 → tx = 0,1,0,0,0,0,0,0,1,1 over 10 cycles; s_ready returns on cycle 10.
- Loopback: 100 random 16-bit words with random 0–20 cycle s_valid gaps, `tx` fed into rx2axi at the same parameters → every m_data equals the sent word, in order, with no extra m_valid.
